// File: rtl/cadence_gen.sv
// Pedal-cadence stimulus generator: square wave with a programmable half-period.
// Optional reed-contact bounce at each edge is built when CADENCE_GEN_BOUNCE_EN is defined.
module cadence_gen #(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned REV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] half_per,
    input  logic [2:0]       bounce_cnt,
    input  logic [7:0]       bounce_len,
    output logic             cadence,
    output logic             rise_pls,
    output logic [REV_W-1:0] rev_cnt,
    output logic             busy
);

`ifdef CADENCE_GEN_BOUNCE_EN
    typedef enum logic [2:0] {StIdle, StLow, StBncR, StHigh, StBncF} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLow, StHigh} state_e;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cad_q, cad_d;
    logic               rise_q, rise_d;
    logic [REV_W-1:0]   rev_q, rev_d;
    logic [CNT_W-1:0]   h_load;
    logic               expire;

    assign h_load = (half_per == '0) ? CNT_W'(1) : half_per;
    // Counter holds the clocks left in the phase, so a value of 1 (or 0) ends it this edge.
    assign expire = (cnt_q[CNT_W-1:1] == '0);

`ifdef CADENCE_GEN_BOUNCE_EN
    logic [7:0] seg_q, seg_d;
    logic [7:0] blen_q, blen_d;
    logic [2:0] pair_q, pair_d;
    logic [7:0] l_load;
    logic       new_lvl;
    logic       seg_end;

    assign l_load  = (bounce_len == '0) ? 8'd1 : bounce_len;
    assign new_lvl = (state_q == StBncR);
    assign seg_end = (seg_q[7:1] == '0);
`else
    logic unused_bnc;
    assign unused_bnc = ^{bounce_cnt, bounce_len};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cad_q   <= 1'b0;
            rise_q  <= 1'b0;
            rev_q   <= '0;
`ifdef CADENCE_GEN_BOUNCE_EN
            seg_q   <= '0;
            blen_q  <= '0;
            pair_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cad_q   <= cad_d;
            rise_q  <= rise_d;
            rev_q   <= rev_d;
`ifdef CADENCE_GEN_BOUNCE_EN
            seg_q   <= seg_d;
            blen_q  <= blen_d;
            pair_q  <= pair_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cad_d   = cad_q;
        rise_d  = 1'b0;
        rev_d   = rev_q;
`ifdef CADENCE_GEN_BOUNCE_EN
        seg_d   = seg_q;
        blen_d  = blen_q;
        pair_d  = pair_q;
`endif
        unique case (state_q)
            StIdle: begin
                cad_d = 1'b0;
                if (en) begin
                    state_d = StLow;
                    cnt_d   = h_load;
                end
            end
            StLow: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!en) begin
                    state_d = StIdle;
                    cad_d   = 1'b0;
                end else begin
                    cad_d  = 1'b1;
                    rise_d = 1'b1;
                    rev_d  = rev_q + REV_W'(1);
`ifdef CADENCE_GEN_BOUNCE_EN
                    if (bounce_cnt != '0) begin
                        state_d = StBncR;
                        seg_d   = l_load;
                        blen_d  = l_load;
                        pair_d  = bounce_cnt;
                    end else begin
                        state_d = StHigh;
                        cnt_d   = h_load;
                    end
`else
                    state_d = StHigh;
                    cnt_d   = h_load;
`endif
                end
            end
            StHigh: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    cad_d = 1'b0;
`ifdef CADENCE_GEN_BOUNCE_EN
                    if (bounce_cnt != '0) begin
                        state_d = StBncF;
                        seg_d   = l_load;
                        blen_d  = l_load;
                        pair_d  = bounce_cnt;
                    end else begin
                        state_d = StLow;
                        cnt_d   = h_load;
                    end
`else
                    state_d = StLow;
                    cnt_d   = h_load;
`endif
                end
            end
`ifdef CADENCE_GEN_BOUNCE_EN
            // Both bounce states share one sequencer; new_lvl is the level being entered.
            StBncR, StBncF: begin
                if (!seg_end) begin
                    seg_d = seg_q - 8'd1;
                end else if (cad_q == new_lvl) begin
                    cad_d = ~new_lvl;
                    seg_d = blen_q;
                end else if (pair_q[2:1] == '0) begin
                    cad_d   = new_lvl;
                    state_d = new_lvl ? StHigh : StLow;
                    cnt_d   = h_load;
                end else begin
                    cad_d  = new_lvl;
                    seg_d  = blen_q;
                    pair_d = pair_q - 3'd1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cad_d   = 1'b0;
            end
        endcase
    end

    assign cadence  = cad_q;
    assign rise_pls = rise_q;
    assign rev_cnt  = rev_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cadence_gen.sv
// Directed bench for cadence_gen: vector table of period/latency cases plus reset, stop and
// rev_cnt wrap sequences. Bounce expectations follow CADENCE_GEN_BOUNCE_EN.
module tb_cadence_gen;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned REV_W = 4;
    localparam int          BOUND = 500;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] half_per;
    logic [2:0]       bounce_cnt;
    logic [7:0]       bounce_len;
    logic             cadence;
    logic             rise_pls;
    logic [REV_W-1:0] rev_cnt;
    logic             busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CNT_W-1:0] hp;
        logic [2:0]       bc;
        logic [7:0]       bl;
        int               lat;
        int               per;
        int               ones;
    } vec_t;

    vec_t vecs[5];

    cadence_gen #(
        .CNT_W(CNT_W),
        .REV_W(REV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .half_per  (half_per),
        .bounce_cnt(bounce_cnt),
        .bounce_len(bounce_len),
        .cadence   (cadence),
        .rise_pls  (rise_pls),
        .rev_cnt   (rev_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int lat, per, ones, rises, k;
        logic seen_rise;

        vecs[0] = '{hp: 24'd10, bc: 3'd0, bl: 8'd0, lat: 10, per: 20, ones: 10};
        vecs[3] = '{hp: 24'd1,  bc: 3'd0, bl: 8'd5, lat: 1,  per: 2,  ones: 1};
`ifdef CADENCE_GEN_BOUNCE_EN
        vecs[1] = '{hp: 24'd0,  bc: 3'd1, bl: 8'd0, lat: 1,  per: 6,  ones: 3};
        vecs[2] = '{hp: 24'd3,  bc: 3'd2, bl: 8'd2, lat: 3,  per: 22, ones: 11};
        vecs[4] = '{hp: 24'd5,  bc: 3'd3, bl: 8'd4, lat: 5,  per: 58, ones: 29};
`else
        vecs[1] = '{hp: 24'd0,  bc: 3'd1, bl: 8'd0, lat: 1,  per: 2,  ones: 1};
        vecs[2] = '{hp: 24'd3,  bc: 3'd2, bl: 8'd2, lat: 3,  per: 6,  ones: 3};
        vecs[4] = '{hp: 24'd5,  bc: 3'd3, bl: 8'd4, lat: 5,  per: 10, ones: 5};
`endif

        // Reset held with en=1 keeps everything idle.
        rst        = 1'b1;
        en         = 1'b1;
        half_per   = 24'd4;
        bounce_cnt = 3'd0;
        bounce_len = 8'd0;
        repeat (3) step();
        chk("rst_cadence", int'(cadence), 0);
        chk("rst_rev", int'(rev_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rise", int'(rise_pls), 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            half_per   = vecs[i].hp;
            bounce_cnt = vecs[i].bc;
            bounce_len = vecs[i].bl;
            en         = 1'b1;
            step();
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
            lat = 0;
            do begin
                step();
                lat++;
            end while (!rise_pls && lat < BOUND);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_rev1", i), int'(rev_cnt), 1);
            per  = 0;
            ones = 0;
            do begin
                ones += int'(cadence);
                step();
                per++;
            end while (!rise_pls && per < BOUND);
            chk($sformatf("v%0d_period", i), per, vecs[i].per);
            chk($sformatf("v%0d_ones", i), ones, vecs[i].ones);
            chk($sformatf("v%0d_rev2", i), int'(rev_cnt), 2);
        end

        // Reset mid-run (partway into a phase) returns to idle at once.
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_cadence", int'(cadence), 0);
        chk("midrst_rev", int'(rev_cnt), 0);
        rst = 1'b0;

        // Stop: drop en during HIGH; HIGH and LOW complete, then idle with no extra rise.
        do_reset();
        half_per   = 24'd4;
        bounce_cnt = 3'd0;
        en         = 1'b1;
        k          = 0;
        do begin
            step();
            k++;
        end while (!rise_pls && k < BOUND);
        chk("stop_first_rise", int'(rise_pls), 1);
        en        = 1'b0;
        k         = 0;
        seen_rise = 1'b0;
        do begin
            step();
            k++;
            if (rise_pls) seen_rise = 1'b1;
        end while (busy && k < BOUND);
        chk("stop_clocks", k, 8);
        chk("stop_extra_rise", int'(seen_rise), 0);
        chk("stop_cadence", int'(cadence), 0);
        chk("stop_rev", int'(rev_cnt), 1);

        // Wrap: 4-bit rev_cnt reads 0 on the 16th rise (with rise_pls) and 1 on the 17th.
        do_reset();
        half_per = 24'd1;
        en       = 1'b1;
        rises    = 0;
        for (int c = 0; c < BOUND && rises < 17; c++) begin
            step();
            if (rise_pls) begin
                rises++;
                if (rises == 16) chk("wrap_at_16", int'(rev_cnt), 0);
                if (rises == 17) chk("wrap_at_17", int'(rev_cnt), 1);
            end
        end
        chk("wrap_rises", rises, 17);
        en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
